// File: rtl/zba_decode_issue.sv
// Zba decode front end: splits each op into {base, index, shift} and
// issues it through a registered output stage backed by a one-entry skid buffer.
module zba_decode_issue #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_base,
    output logic [XLEN-1:0]  out_index,
    output logic [5:0]       out_sh,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] index;
        logic [5:0]      sh;
        logic [4:0]      rd;
        logic            ill;
    } op_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f3_shn;
    logic       is_shadd;
    logic       is_adduw;
    logic       is_shadduw;
    logic       is_slliuw;
    logic [XLEN-1:0] rs1_zext;

    op_t dec;
    op_t out_q, out_d;
    op_t skid_q, skid_d;
    logic out_v_q, out_v_d;
    logic skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_xfer;
    logic out_xfer;
    logic out_free;

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign f7       = in_instr[31:25];
    assign f3_shn   = (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    assign rs1_zext = {{(XLEN-32){1'b0}}, in_rs1[31:0]};

    assign is_shadd   = (opc == 7'b0110011) && (f7 == 7'b0010000) && f3_shn;
    assign is_adduw   = (opc == 7'b0111011) && (f7 == 7'b0000100)
                        && (f3 == 3'b000);
    assign is_shadduw = (opc == 7'b0111011) && (f7 == 7'b0010000) && f3_shn;
    assign is_slliuw  = (opc == 7'b0011011) && (f3 == 3'b001)
                        && (in_instr[31:26] == 6'b000010);

    // f3 of 010/100/110 maps directly onto shift 1/2/3 via f3[2:1]
    always_comb begin
        dec     = '0;
        dec.rd  = in_instr[11:7];
        dec.ill = 1'b0;
        unique case (1'b1)
            is_shadd: begin
                dec.base  = in_rs2;
                dec.index = in_rs1;
                dec.sh    = {4'b0, f3[2:1]};
            end
            is_adduw: begin
                dec.base  = in_rs2;
                dec.index = rs1_zext;
            end
            is_shadduw: begin
                dec.base  = in_rs2;
                dec.index = rs1_zext;
                dec.sh    = {4'b0, f3[2:1]};
            end
            is_slliuw: begin
                dec.index = rs1_zext;
                dec.sh    = in_instr[25:20];
            end
            default: dec.ill = 1'b1;
        endcase
    end

    assign in_ready = ~skid_v_q;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_v_q & out_ready;
    assign out_free = ~out_v_q | out_ready;

    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;
        if (out_xfer && out_q.ill && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
        // A full skid implies in_ready=0, so it never competes with a new input
        if (out_free) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else if (in_xfer) begin
                out_d   = dec;
                out_v_d = 1'b1;
            end else begin
                out_v_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = out_v_q;
    assign out_base    = out_q.base;
    assign out_index   = out_q.index;
    assign out_sh      = out_q.sh;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.ill;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_zba_decode_issue.sv
// Bench for zba_decode_issue: vector table, directed handshake
// sequences and a scoreboarded random stream against a reference decode.
module tb_zba_decode_issue;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] index;
        logic [5:0]  sh;
        logic [4:0]  rd;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        dec_t        exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [63:0]      in_rs1;
    logic [63:0]      in_rs2;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_base;
    logic [63:0]      out_index;
    logic [5:0]       out_sh;
    logic [4:0]       out_rd;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int mcnt  = 0;
    dec_t sb[$];

    zba_decode_issue #(.XLEN(64), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_base    (out_base),
        .out_index   (out_index),
        .out_sh      (out_sh),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dec_t ref_dec(input logic [31:0] w,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
        dec_t r;
        logic [63:0] za;
        logic [5:0]  s;
        logic        okf3;
        r    = '0;
        r.rd = w[11:7];
        za   = {32'h0, a[31:0]};
        okf3 = 1'b1;
        case (w[14:12])
            3'd2:    s = 6'd1;
            3'd4:    s = 6'd2;
            3'd6:    s = 6'd3;
            default: begin s = 6'd0; okf3 = 1'b0; end
        endcase
        r.ill = 1'b1;
        case (w[6:0])
            7'h33: if (w[31:25] == 7'h10 && okf3) begin
                r.base = b; r.index = a; r.sh = s; r.ill = 1'b0;
            end
            7'h3B: begin
                if (w[31:25] == 7'h04 && w[14:12] == 3'd0) begin
                    r.base = b; r.index = za; r.ill = 1'b0;
                end
                if (w[31:25] == 7'h10 && okf3) begin
                    r.base = b; r.index = za; r.sh = s; r.ill = 1'b0;
                end
            end
            7'h1B: if (w[14:12] == 3'd1 && w[31:26] == 6'b000010) begin
                r.index = za; r.sh = w[25:20]; r.ill = 1'b0;
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [2:0]  f3;
        logic [31:0] w;
        rd = 5'($urandom);
        ra = 5'($urandom);
        rb = 5'($urandom);
        f3 = 3'(2 * $urandom_range(1, 3));
        case ($urandom_range(0, 7))
            0: w = {7'h10, rb, ra, f3, rd, 7'h33};
            1: w = {7'h04, rb, ra, 3'd0, rd, 7'h3B};
            2: w = {7'h10, rb, ra, f3, rd, 7'h3B};
            3: w = {6'b000010, 6'($urandom), ra, 3'd1, rd, 7'h1B};
            4: w = $urandom;
            5: w = {7'h10, rb, ra, f3, rd, 7'h33} ^ (32'h1 << $urandom_range(25, 31));
            6: w = {7'h10, rb, ra, 3'(2 * $urandom_range(0, 3) + 1), rd, 7'h33};
            default: w = {12'h0, ra, 3'd0, rd, 7'h13};
        endcase
        return w;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        in_instr = v.instr;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".base"}, out_base, v.exp.base);
        chk({tag, ".index"}, out_index, v.exp.index);
        chk({tag, ".sh"}, 64'(out_sh), 64'(v.exp.sh));
        chk({tag, ".rd"}, 64'(out_rd), 64'(v.exp.rd));
        chk({tag, ".ill"}, 64'(out_illegal), 64'(v.exp.ill));
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [4:0] rd, input logic [63:0] a);
        in_instr = {7'h10, 5'd2, 5'd1, 3'b010, rd, 7'h33};
        in_rs1   = a;
        in_rs2   = a + 64'h100;
        in_valid = 1'b1;
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle
    initial begin : monitor
        dec_t e;
        dec_t prev;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                mcnt = 0;
                prev_stall = 1'b0;
            end else begin
                chk("cnt", 64'(illegal_cnt), 64'(mcnt));
                if (prev_stall) begin
                    chk("stall.valid", 64'(out_valid), 64'd1);
                    chk("stall.data", {out_base ^ out_index, 64'(out_sh),
                        64'(out_rd), 64'(out_illegal)} == {prev.base ^ prev.index,
                        64'(prev.sh), 64'(prev.rd), 64'(prev.ill)} ? 64'd1 : 64'd0,
                        64'd1);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb.empty", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb.base", out_base, e.base);
                        chk("sb.index", out_index, e.index);
                        chk("sb.sh", 64'(out_sh), 64'(e.sh));
                        chk("sb.rd", 64'(out_rd), 64'(e.rd));
                        chk("sb.ill", 64'(out_illegal), 64'(e.ill));
                        if (e.ill && mcnt < CMAX) mcnt++;
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(ref_dec(in_instr, in_rs1, in_rs2));
                    n_acc++;
                end
                prev_stall = out_valid && !out_ready;
                prev = '{out_base, out_index, out_sh, out_rd, out_illegal};
            end
        end
    end

    vec_t tbl[10];
    vec_t addi;
    vec_t nm;

    initial begin : stim
        int cyc;
        tbl[0] = '{{7'h10, 5'd2, 5'd1, 3'b100, 5'd5, 7'h33}, 64'h10, 64'h1000,
                   '{64'h1000, 64'h10, 6'd2, 5'd5, 1'b0}};
        tbl[1] = '{{7'h10, 5'd2, 5'd1, 3'b110, 5'd7, 7'h3B},
                   64'hFFFF_FFFF_8000_0001, 64'h20,
                   '{64'h20, 64'h0000_0000_8000_0001, 6'd3, 5'd7, 1'b0}};
        tbl[2] = '{{6'b000010, 6'd40, 5'd1, 3'b001, 5'd9, 7'h1B},
                   64'h1_2345_6789, 64'hAAAA,
                   '{64'h0, 64'h2345_6789, 6'd40, 5'd9, 1'b0}};
        tbl[3] = '{{7'h04, 5'd2, 5'd1, 3'b000, 5'd1, 7'h3B},
                   64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                   '{64'h1, 64'hFFFF_FFFF, 6'd0, 5'd1, 1'b0}};
        tbl[4] = '{{7'h10, 5'd2, 5'd1, 3'b010, 5'd31, 7'h33},
                   64'hFFFF_FFFF_8000_0000, 64'h5,
                   '{64'h5, 64'hFFFF_FFFF_8000_0000, 6'd1, 5'd31, 1'b0}};
        tbl[5] = '{{7'h10, 5'd2, 5'd1, 3'b010, 5'd3, 7'h3B},
                   64'h1_0000_0003, 64'h7,
                   '{64'h7, 64'h3, 6'd1, 5'd3, 1'b0}};
        tbl[6] = '{32'h0000_0013, 64'h55, 64'h66,
                   '{64'h0, 64'h0, 6'd0, 5'd0, 1'b1}};
        tbl[7] = '{{7'h11, 5'd2, 5'd1, 3'b010, 5'd4, 7'h33}, 64'h9, 64'h8,
                   '{64'h0, 64'h0, 6'd0, 5'd4, 1'b1}};
        tbl[8] = '{{7'h00, 5'd2, 5'd1, 3'b000, 5'd6, 7'h33}, 64'h9, 64'h8,
                   '{64'h0, 64'h0, 6'd0, 5'd6, 1'b1}};
        tbl[9] = '{{6'b000011, 6'd4, 5'd1, 3'b001, 5'd8, 7'h1B}, 64'h9, 64'h8,
                   '{64'h0, 64'h0, 6'd0, 5'd8, 1'b1}};
        addi = tbl[6];
        nm   = tbl[7];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.ready", 64'(in_ready), 64'd1);
        chk("rst.cnt", 64'(illegal_cnt), 64'd0);
        chk("rst.data", out_base | out_index | 64'(out_sh) | 64'(out_rd)
            | 64'(out_illegal), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 5; k++) begin
            apply(addi, "addi");
            chk("addi.cnt", 64'(illegal_cnt), 64'(k + 1 > CMAX ? CMAX : k + 1));
        end
        apply(nm, "nearmiss");

        for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back stream with the sink always ready never fills the skid
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(5'(i), 64'(i));
            @(posedge clk); #1;
            chk("burst.ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(5'd1, 64'hA);
        @(posedge clk); #1;
        chk("bp.A.rd", 64'(out_rd), 64'd1);
        chk("bp.A.ready", 64'(in_ready), 64'd1);
        send(5'd2, 64'hB);
        @(posedge clk); #1;
        chk("bp.full", 64'(in_ready), 64'd0);
        send(5'd3, 64'hC);
        @(posedge clk); #1;
        chk("bp.C.held", 64'(in_ready), 64'd0);
        chk("bp.A.held", 64'(out_rd), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.B.rd", 64'(out_rd), 64'd2);
        chk("bp.reopen", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.C.rd", 64'(out_rd), 64'd3);
        chk("bp.C.valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        chk("bp.drained", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        send(5'd10, 64'hD);
        @(posedge clk); #1;
        send(5'd11, 64'hE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rm.full", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rm.valid", 64'(out_valid), 64'd0);
        chk("rm.ready", 64'(in_ready), 64'd1);
        chk("rm.cnt", 64'(illegal_cnt), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rm.quiet", 64'(out_valid), 64'd0);
        end

        cyc = 0;
        n_acc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid  = ($urandom_range(0, 9) < 8);
            in_instr  = rand_instr();
            in_rs1    = {$urandom, $urandom};
            in_rs2    = {$urandom, $urandom};
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand.budget", 64'(n_acc >= 10000), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("drain.sb", 64'(sb.size()), 64'd0);
        chk("drain.valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
